// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-ported data RAM: combinational grant, burst limit, registered read return.
// Optional build macro DMEM_ARB_RR_EN: round-robin tie-break from IDLE (default is fixed priority to m0).
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_spo,
    output logic          busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last_winner;
    logic          tie_m1;
    logic          win0, win1;

`ifdef DMEM_ARB_RR_EN
    // last_winner resets to 1, so the first tie after reset goes to m0
    assign tie_m1 = ~last_winner;
`else
    assign tie_m1 = 1'b0;
`endif

    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    win1 = tie_m1;
                    win0 = ~tie_m1;
                end else begin
                    win0 = m0_req;
                    win1 = m1_req;
                end
            end
            OWN0: begin
                if (m0_req && (!m1_req || cnt < CNT_MAX)) win0 = 1'b1;
                else                                      win1 = m1_req;
            end
            OWN1: begin
                if (m1_req && (!m0_req || cnt < CNT_MAX)) win1 = 1'b1;
                else                                      win0 = m0_req;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        if (win0)      state_nxt = OWN0;
        else if (win1) state_nxt = OWN1;
        if ((win0 && state == OWN0) || (win1 && state == OWN1))
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        else if (win0 || win1)
            cnt_nxt = CW'(1);
    end

    // Outputs toward the masters and the RAM are held low while reset is asserted
    always_comb begin
        m0_gnt = win0 & rst;
        m1_gnt = win1 & rst;
        mem_we = 1'b0;
        mem_a  = '0;
        mem_d  = '0;
        if (rst && win0) begin
            mem_we = m0_we;
            mem_a  = m0_addr;
            mem_d  = m0_wdata;
        end else if (rst && win1) begin
            mem_we = m1_we;
            mem_a  = m1_addr;
            mem_d  = m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_winner <= 1'b1;
            m0_rvalid   <= 1'b0;
            m1_rvalid   <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (win0 || win1) last_winner <= win1;
            m0_rvalid <= win0 & ~m0_we;
            m1_rvalid <= win1 & ~m1_we;
            if (win0 && !m0_we) m0_rdata <= mem_spo;
            if (win1 && !m1_we) m1_rdata <= mem_spo;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random traffic against a reference arbitration model,
// read responses checked through a scoreboard queue by an independent monitor.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_we, busy;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d, mem_spo;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_spo(mem_spo), .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment RAM: 16 words, asynchronous read, write on rising edge
    logic [DW-1:0] ram [16] = '{default: '0};
    assign mem_spo = ram[mem_a[3:0]];
    always @(posedge clk) if (mem_we) ram[mem_a[3:0]] <= mem_d;

    typedef struct {int m; logic [DW-1:0] d;} exp_t;
    exp_t sb[$];

    logic [DW-1:0] refm [16] = '{default: '0};
    int owner = -1, run = 0, last_win = 1;
    int last_w = -1, act_w = -1;
    int n_cmp = 0, n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(logic r0, logic r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (owner >= 0) return (run < MAX_BURST) ? owner : 1 - owner;
`ifdef DMEM_ARB_RR_EN
        return 1 - last_win;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        owner = -1; run = 0; last_win = 1;
        sb.delete();
    endtask

    // Called just after a negedge with inputs applied; checks this cycle and advances to the next negedge
    task automatic tick();
        int w, a;
        logic ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        #1;
        w = pick(m0_req, m1_req);
        ewe = 1'b0; ea = '0; ed = '0;
        if (w == 0) begin ewe = m0_we; ea = m0_addr; ed = m0_wdata; end
        if (w == 1) begin ewe = m1_we; ea = m1_addr; ed = m1_wdata; end
        act_w = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
        chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
        chk("two_gnt", 32'(m0_gnt & m1_gnt), 32'(0));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_a", mem_a, ea);
        chk("mem_d", mem_d, ed);
        if (w >= 0) begin
            a = int'(ea[3:0]);
            if (ewe) refm[a] = ed;
            else     sb.push_back('{w, refm[a]});
            if (w == owner) run = (run < MAX_BURST) ? run + 1 : run;
            else begin owner = w; run = 1; end
            last_win = w;
        end else begin
            owner = -1; run = 0;
        end
        last_w = w;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic new_req0(int pct);
        m0_req = ($urandom_range(0, 99) < pct);
        m0_we = $urandom_range(0, 1) == 1;
        m0_addr = 32'($urandom_range(0, 15));
        m0_wdata = $urandom;
    endtask

    task automatic new_req1(int pct);
        m1_req = ($urandom_range(0, 99) < pct);
        m1_we = $urandom_range(0, 1) == 1;
        m1_addr = 32'($urandom_range(0, 15));
        m1_wdata = $urandom;
    endtask

    // Read-response monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("m0_rvalid", 32'(m0_rvalid), 32'(e.m == 0));
                chk("m1_rvalid", 32'(m1_rvalid), 32'(e.m == 1));
                chk("rdata", (e.m == 0) ? m0_rdata : m1_rdata, e.d);
            end else if (m0_rvalid || m1_rvalid) begin
                chk("spurious_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            end
        end
    end

    initial begin
        string seq;
        logic [DW-1:0] saved;
        int exp_tie;

        // Reset with a pending m0 write
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd5; m0_wdata = 32'h1;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Write then read address 5 from m0
        rst = 1'b1;
        m0_wdata = 32'hDEAD_BEEF;
        tick();
        m0_we = 1'b0;
        tick();
        chk("wr_rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("wr_rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("wr_rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
        m0_req = 1'b0;
        tick();
        chk("rvalid_pulse", 32'(m0_rvalid), 32'd0);

        // Continuous contention: burst limit alternates ownership
        do_reset();
        m0_we = 1'b1; m1_we = 1'b1;
        m0_addr = 32'd1; m1_addr = 32'd2;
        m0_req = 1'b1; m1_req = 1'b1;
        seq = "";
        for (int i = 0; i < 12; i++) begin
            tick();
            seq = {seq, (act_w == 0) ? "0" : (act_w == 1) ? "1" : "-"};
            if (act_w == 0) m0_wdata = $urandom;
            if (act_w == 1) m1_wdata = $urandom;
        end
        n_cmp++;
        if (seq != "000011110000") begin
            n_bad++;
            $display("FAIL burst_seq: got %s expected 000011110000", seq);
        end

        // Tie-break after a lone m0 grant and an idle cycle
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1;
        tick();
        m0_req = 1'b0;
        tick();
        m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd2;
        tick();
`ifdef DMEM_ARB_RR_EN
        exp_tie = 1;
`else
        exp_tie = 0;
`endif
        chk("tie_winner", 32'(act_w), 32'(exp_tie));

        // Owner withdraws while the other master waits
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m0_addr = 32'(i + 3); m0_wdata = $urandom;
            tick();
            chk("withdraw_m0_run", 32'(act_w), 32'd0);
        end
        m0_req = 1'b0;
        tick();
        chk("withdraw_switch", 32'(act_w), 32'd1);
        chk("withdraw_busy", 32'(busy), 32'd1);
        m1_req = 1'b0;
        tick();
        #1;
        chk("withdraw_idle", 32'(busy), 32'd0);
        @(negedge clk);
        last_w = -1;
        owner = -1; run = 0;

        // Reset asserted in the middle of an m1 write burst
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd7; m1_wdata = 32'hA5A5_0007;
        tick();
        m1_addr = 32'd9; m1_wdata = 32'h1234_5678;
        saved = refm[9];
        #1;
        chk("midrst_pre_gnt", 32'(m1_gnt), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("midrst_mem_a", mem_a, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ram_kept", ram[9], saved);
        chk("midrst_busy", 32'(busy), 32'd0);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd7;
        m1_we = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_tie_m0", 32'(act_w), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (!m0_req || last_w == 0) new_req0(75);
            if (!m1_req || last_w == 1) new_req1(75);
            tick();
        end

        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data RAM between the core load/store path (master 0) and a loader/debug port (master 1). Sits between those requesters and the data RAM's write-enable/address/write-data/async-read port. Grants at most one access per cycle, enforces a burst limit so neither master starves, and returns read data through a registered response.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_BURST, 4, max consecutive grants to one master while the other is requesting (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_req / m1_req  in  1  access request; held with addr/we/wdata stable until gnt
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  word address
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid, one-cycle pulse
- m0_rdata / m1_rdata  out  DW  registered read data
- mem_we  out  1  RAM write enable
- mem_a  out  AW  RAM address
- mem_d  out  DW  RAM write data
- mem_spo  in  DW  RAM asynchronous read data
- busy  out  1  state != IDLE

## Operation
- State: fsm {IDLE, OWN0, OWN1}; cnt (consecutive grants, 0..MAX_BURST, saturating); last_winner (1 bit).
- Arbitration (combinational from state, cnt, reqs):
  - IDLE: single requester wins; both → tie-break (see Configuration).
  - OWN0: m0_req && (!m1_req || cnt < MAX_BURST) → m0; else m1_req → m1; else none. OWN1 symmetric.
- Next state: winner m0 → OWN0, m1 → OWN1, none → IDLE. cnt = cnt+1 (saturating) if winner == current owner, 1 on switch or from IDLE, 0 on no grant. last_winner updated on every grant.
- Memory drive: mem_a/mem_d from winner; mem_we = winner's we & gnt; all zero when no grant.
- Read grant: mem_spo captured into winner's rdata at that edge; winner's rvalid = 1 for the next cycle only. Writes produce no rvalid. rdata holds its last value otherwise.
- At most one of m0_gnt/m1_gnt high; at most one rvalid high.

## Timing
- Grant latency 0: gnt combinational in the cycle the request is presented and the master wins.
- Write commits at the rising edge ending the grant cycle.
- Read latency 1: rvalid/rdata valid the cycle after gnt.
- Back-to-back: a master may be granted every cycle; reads pipeline (grant N, rvalid N+1, overlapping grant N+1).
- Reset values: fsm=IDLE, cnt=0, last_winner=1, m0/m1_rvalid=0, m0/m1_rdata=0, busy=0. While rst=0, gnt, mem_we, mem_a, mem_d forced 0 regardless of req.
- Reset mid-burst: all state clears asynchronously; the in-flight write at assertion is not committed; pending rvalid dropped.
- Request withdrawn by owner: switches to other requester next cycle with cnt=1, or IDLE.

## Configuration
- DMEM_ARB_RR_EN defined: IDLE tie → master != last_winner (round-robin; after reset m0 first).
- Not defined: IDLE tie → m0 always (fixed priority). Burst limit applies in both builds.

## Test plan
- Reset: rst=0 with m0_req=1, m0_we=1 → m0_gnt=0, mem_we=0, rvalid=0, rdata=0; release → first grant to m0 same cycle.
- m0 writes addr 5 = 0xDEADBEEF, then reads addr 5 → gnt each cycle, m0_rvalid=1 one cycle after read grant, m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Both request continuously from IDLE (MAX_BURST=4) → grants m0×4, m1×4, m0×4; never two gnts in one cycle.
- m0 alone once, one idle cycle, then both request → with DMEM_ARB_RR_EN m1 wins; without it m0 wins.
- m0 granted 3 cycles then drops req while m1 requesting → m1 granted next cycle, cnt=1, busy stays 1; both drop → IDLE, busy=0.
- rst pulled low mid-burst during an m1 write → mem_we=0 immediately, RAM location unchanged, after release fsm=IDLE and tie goes to m0.
